f1_kuznyechik_mode: RTL and testbench
=====================================

Name: f1_kuznyechik_mode

Overview:
Block-cipher mode engine that sits in front of the Kuznyechik core (f1_kuznyechik) and drives its strobe-handshake interface. Adds ECB, CBC and CTR chaining, an IV/counter register and a parametrised input block FIFO, so a message of any number of 128-bit blocks streams through one key schedule. Key loading passes through to the core. Output blocks are delivered in order, one ready_s strobe per block.

Parameters:
FIFO_DEPTH, 4, input block FIFO depth (power of 2, 2..16)
CTR_BITS, 64, width of the incrementing counter field in CTR mode (multiple of 8, 8..128)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
ready  out  1  level: engine idle, FIFO empty, core idle
cfg_valid_s  in  1  strobe: latch mode, encrypt_decrypt_n, iv
mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved
encrypt_decrypt_n  in  1  1 encrypt, 0 decrypt (ignored in CTR)
iv  in  128  IV (CBC) or initial counter block (CTR)
skey_valid_s  in  1  strobe: load key
skey  in  256  key
skey_ready_s  out  1  strobe: key schedule done
valid_s  in  1  strobe: push din into FIFO
din  in  128  data block
full  out  1  level: FIFO full
ready_s  out  1  strobe: dout valid
dout  out  128  result block
err  out  1  sticky: overflow, illegal cfg or illegal key load; cleared only by reset
core_skey_valid_s  out  1  to core
core_skey  out  256  to core
core_skey_ready_s  in  1  from core
core_valid_s  out  1  to core
core_encrypt_decrypt_n  out  1  to core
core_din  out  128  to core
core_ready  in  1  core idle level
core_ready_s  in  1  core result strobe
core_dout  in  128  core result

Behaviour:
- Reset: state IDLE; FIFO empty; mode_r = ECB; dir_r = 1; chain_r = 0; ready, skey_ready_s, ready_s, err, full, core_* strobes = 0; dout = 0. Reset mid-operation discards all FIFO contents and in-flight blocks. The core has its own reset.
- Byte order: byte 0 is dout[7:0]. The counter field is bytes [CTR_BITS/8-1:0] with byte 0 least significant.
- States: IDLE, KEY, ISSUE, WAIT.
  - IDLE -> KEY on skey_valid_s, when the FIFO is empty. Otherwise the key is rejected and err is set.
  - IDLE -> ISSUE when the FIFO is non-empty and core_ready = 1.
- KEY: core_skey_valid_s is asserted in the same cycle as skey_valid_s, and skey is forwarded. On core_skey_ready_s: skey_ready_s pulses in the next cycle and the state returns to IDLE.
- cfg_valid_s:
  - Accepted only in IDLE with the FIFO empty and mode != 11.
  - Otherwise ignored and err is set.
  - On accept: mode_r <- mode, dir_r <- encrypt_decrypt_n, chain_r <- iv.
  - cfg_valid_s together with valid_s in the same cycle: the config is applied first; the pushed block uses the new config.
- ISSUE (1 cycle): pulse core_valid_s with core_din set per mode, then go to WAIT.
  - ECB: FIFO head; core direction = dir_r.
  - CBC encrypt: head ^ chain_r.
  - CBC decrypt: head; the head is also saved in hold_r.
  - CTR: chain_r; core direction = encrypt always; head saved in hold_r.
  - Pop the FIFO in the same cycle.
- WAIT: on core_ready_s, register dout and pulse ready_s in the next cycle.
  - ECB: dout = core_dout.
  - CBC encrypt: dout = core_dout; chain_r <- core_dout.
  - CBC decrypt: dout = core_dout ^ chain_r; chain_r <- hold_r.
  - CTR: dout = core_dout ^ hold_r; the counter field of chain_r increments modulo 2^CTR_BITS; upper bytes are unchanged (no carry out).
  - Next state: ISSUE if the FIFO is non-empty, else IDLE.
- Latency: FIFO head valid in IDLE -> core_valid_s 2 cycles later (IDLE->ISSUE); core_ready_s -> ready_s 1 cycle.
- FIFO behaviour:
  - valid_s while full: block dropped and err set.
  - full is registered; it reflects a push in the next cycle.
  - A push and a pop in the same cycle while full is accepted.
- ready = (state == IDLE) & FIFO empty & core_ready. It is registered, so it falls 1 cycle after an accepted strobe.
- skey_valid_s and valid_s in the same IDLE cycle with the FIFO empty: the key is taken and the block is queued; the block is issued after KEY completes.

Decomposition:
- Package f1_kuz_mode_pkg:
  - BLOCK_W = 128, KEY_W = 256.
  - mode enum (ECB, CBC, CTR, RSVD).
  - state enum.
  - function ctr_inc(block, CTR_BITS).
- Sub-module f1_blk_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with push, pop, dout, empty, full. The head is valid combinationally. Reset is async active-high.

Test Plan:
- ECB encrypt, key 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef, din 1122334455667700ffeeddccbbaa9988 -> dout 7f679d90bebc24305a468d42b9d4edcd, one ready_s pulse, err = 0.
- CBC encrypt then decrypt of 3 blocks with iv = 0123...ef: the ciphertext matches the software model. Decrypting it with the same iv returns the plaintext. The second encrypt core_din equals P2 ^ C1.
- CTR with CTR_BITS = 8, iv low byte ff, byte1 = 5a: the second block counter has low byte 00 and byte1 still 5a. Encrypt and decrypt give identical results.
- FIFO_DEPTH = 4: push 5 blocks back-to-back while the core is stalled. full asserts after the 4th, the 5th is dropped, err = 1, and 4 ready_s pulses follow in order.
- cfg_valid_s with mode = 11, and cfg_valid_s while the FIFO is non-empty: both are ignored, err = 1, and the previous mode and chain are unchanged.
- Reset asserted during WAIT with 2 blocks queued: all outputs reset immediately, no ready_s afterwards, and ready returns once core_ready = 1.

Source files
------------

// File: rtl/f1_kuz_mode_pkg.sv
// Shared types and helpers for the Kuznyechik block-cipher mode engine.
package f1_kuz_mode_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 256;

  typedef enum logic [1:0] {
    MODE_ECB  = 2'b00,
    MODE_CBC  = 2'b01,
    MODE_CTR  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEY,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  // Increment the low ctr_bits of a counter block; upper bits never see a carry.
  function automatic logic [BLOCK_W-1:0] ctr_inc(input logic [BLOCK_W-1:0] blk,
                                                 input int ctr_bits);
    logic [BLOCK_W-1:0] mask;
    mask = (ctr_bits >= BLOCK_W) ? '1 : ((BLOCK_W'(1) << ctr_bits) - BLOCK_W'(1));
    return (blk & ~mask) | ((blk + BLOCK_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/f1_blk_fifo.sv
// Synchronous block FIFO with a combinational head and registered empty/full flags.
module f1_blk_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/f1_kuznyechik_mode.sv
// ECB/CBC/CTR chaining engine in front of the Kuznyechik core's strobe interface.
module f1_kuznyechik_mode
  import f1_kuz_mode_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CTR_BITS   = 64
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ready,
  input  logic               cfg_valid_s,
  input  logic [1:0]         mode,
  input  logic               encrypt_decrypt_n,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               skey_valid_s,
  input  logic [KEY_W-1:0]   skey,
  output logic               skey_ready_s,
  input  logic               valid_s,
  input  logic [BLOCK_W-1:0] din,
  output logic               full,
  output logic               ready_s,
  output logic [BLOCK_W-1:0] dout,
  output logic               err,
  output logic               core_skey_valid_s,
  output logic [KEY_W-1:0]   core_skey,
  input  logic               core_skey_ready_s,
  output logic               core_valid_s,
  output logic               core_encrypt_decrypt_n,
  output logic [BLOCK_W-1:0] core_din,
  input  logic               core_ready,
  input  logic               core_ready_s,
  input  logic [BLOCK_W-1:0] core_dout
);

  state_e             state;
  mode_e              mode_r;
  logic               dir_r;
  logic [BLOCK_W-1:0] chain_r, hold_r, head;
  logic               fifo_empty, fifo_pop;
  logic               idle_free, key_accept, cfg_ok, overflow;

  f1_blk_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (valid_s),
    .pop   (fifo_pop),
    .din   (din),
    .dout  (head),
    .empty (fifo_empty),
    .full  (full)
  );

  assign idle_free  = (state == ST_IDLE) && fifo_empty;
  assign key_accept = skey_valid_s && idle_free;
  assign cfg_ok     = cfg_valid_s && idle_free && (mode != MODE_RSVD);
  assign fifo_pop   = (state == ST_ISSUE);
  assign overflow   = valid_s && full && !fifo_pop;

  // The key strobe reaches the core in the same cycle it is accepted.
  assign core_skey_valid_s = key_accept && !reset;
  assign core_skey         = skey;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= ST_IDLE;
      mode_r                 <= MODE_ECB;
      dir_r                  <= 1'b1;
      chain_r                <= '0;
      hold_r                 <= '0;
      ready                  <= 1'b0;
      skey_ready_s           <= 1'b0;
      ready_s                <= 1'b0;
      err                    <= 1'b0;
      dout                   <= '0;
      core_valid_s           <= 1'b0;
      core_encrypt_decrypt_n <= 1'b1;
      core_din               <= '0;
    end else begin
      skey_ready_s <= 1'b0;
      ready_s      <= 1'b0;
      core_valid_s <= 1'b0;
      ready        <= (state == ST_IDLE) && fifo_empty && core_ready;

      if ((cfg_valid_s && !cfg_ok) || (skey_valid_s && !key_accept) || overflow)
        err <= 1'b1;

      if (cfg_ok) begin
        mode_r  <= mode_e'(mode);
        dir_r   <= encrypt_decrypt_n;
        chain_r <= iv;
      end

      unique case (state)
        ST_IDLE: begin
          if (key_accept)                    state <= ST_KEY;
          else if (!fifo_empty && core_ready) state <= ST_ISSUE;
        end
        ST_KEY: begin
          if (core_skey_ready_s) begin
            skey_ready_s <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // CTR always runs the core forwards; the keystream is XORed on return.
          core_valid_s           <= 1'b1;
          core_encrypt_decrypt_n <= (mode_r == MODE_CTR) ? 1'b1 : dir_r;
          hold_r                 <= head;
          case (mode_r)
            MODE_CBC: core_din <= dir_r ? (head ^ chain_r) : head;
            MODE_CTR: core_din <= chain_r;
            default:  core_din <= head;
          endcase
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_ready_s) begin
            ready_s <= 1'b1;
            case (mode_r)
              MODE_CBC: begin
                if (dir_r) begin
                  dout    <= core_dout;
                  chain_r <= core_dout;
                end else begin
                  dout    <= core_dout ^ chain_r;
                  chain_r <= hold_r;
                end
              end
              MODE_CTR: begin
                dout    <= core_dout ^ hold_r;
                chain_r <= ctr_inc(chain_r, CTR_BITS);
              end
              default: dout <= core_dout;
            endcase
            state <= fifo_empty ? ST_IDLE : ST_ISSUE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_kuznyechik_mode.sv
// Bench for the mode engine; the core is a stand-in keyed rotate/add cipher with fixed latency.
module tb_f1_kuznyechik_mode;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ready;
  logic         cfg_valid_s = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         encrypt_decrypt_n = 1'b1;
  logic [127:0] iv = '0;
  logic         skey_valid_s = 1'b0;
  logic [255:0] skey = '0;
  logic         skey_ready_s;
  logic         valid_s = 1'b0;
  logic [127:0] din = '0;
  logic         full;
  logic         ready_s;
  logic [127:0] dout;
  logic         err;
  logic         core_skey_valid_s;
  logic [255:0] core_skey;
  logic         core_skey_ready_s = 1'b0;
  logic         core_valid_s;
  logic         core_encrypt_decrypt_n;
  logic [127:0] core_din;
  logic         core_ready;
  logic         core_ready_s = 1'b0;
  logic [127:0] core_dout = '0;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  f1_kuznyechik_mode #(.FIFO_DEPTH(4), .CTR_BITS(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .ready                  (ready),
    .cfg_valid_s            (cfg_valid_s),
    .mode                   (mode),
    .encrypt_decrypt_n      (encrypt_decrypt_n),
    .iv                     (iv),
    .skey_valid_s           (skey_valid_s),
    .skey                   (skey),
    .skey_ready_s           (skey_ready_s),
    .valid_s                (valid_s),
    .din                    (din),
    .full                   (full),
    .ready_s                (ready_s),
    .dout                   (dout),
    .err                    (err),
    .core_skey_valid_s      (core_skey_valid_s),
    .core_skey              (core_skey),
    .core_skey_ready_s      (core_skey_ready_s),
    .core_valid_s           (core_valid_s),
    .core_encrypt_decrypt_n (core_encrypt_decrypt_n),
    .core_din               (core_din),
    .core_ready             (core_ready),
    .core_ready_s           (core_ready_s),
    .core_dout              (core_dout)
  );

  function automatic logic [127:0] tenc(input logic [255:0] k, input logic [127:0] x);
    logic [127:0] t;
    t = x ^ k[127:0];
    return {t[114:0], t[127:115]} + k[255:128];
  endfunction

  function automatic logic [127:0] tdec(input logic [255:0] k, input logic [127:0] y);
    logic [127:0] t;
    t = y - k[255:128];
    return {t[12:0], t[127:13]} ^ k[127:0];
  endfunction

  // Core stand-in: key schedule 3 cycles, block 3 cycles; hold forces busy, stall freezes it.
  logic [255:0] core_key = '0;
  logic         core_idle_r = 1'b1;
  int           core_cnt = 0;
  int           key_cnt = 0;
  logic [127:0] core_res = '0;
  logic [127:0] din_log[$];
  bit           core_hold = 1'b0;
  bit           core_stall = 1'b0;

  assign core_ready = core_idle_r & ~core_hold;

  always @(posedge clk) begin
    core_ready_s      <= 1'b0;
    core_skey_ready_s <= 1'b0;
    if (key_cnt != 0) begin
      key_cnt <= key_cnt - 1;
      if (key_cnt == 1) core_skey_ready_s <= 1'b1;
    end else if (core_skey_valid_s) begin
      core_key <= core_skey;
      key_cnt  <= 3;
    end
    if (!core_idle_r) begin
      if (!core_stall) begin
        if (core_cnt == 1) begin
          core_ready_s <= 1'b1;
          core_dout    <= core_res;
          core_idle_r  <= 1'b1;
        end
        core_cnt <= core_cnt - 1;
      end
    end else if (core_valid_s) begin
      core_idle_r <= 1'b0;
      core_cnt    <= 3;
      core_res    <= core_encrypt_decrypt_n ? tenc(core_key, core_din) : tdec(core_key, core_din);
      din_log.push_back(core_din);
    end
  end

  logic [127:0] out_q[$];
  int           skey_cnt = 0;

  always @(negedge clk) begin
    if (ready_s) out_q.push_back(dout);
    if (skey_ready_s) skey_cnt <= skey_cnt + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] out_at(input int i);
    return (i < out_q.size()) ? out_q[i] : 128'hx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_outs(input int n, input string name);
    int cyc;
    cyc = 0;
    while (out_q.size() < n && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    n_checks++;
    if (out_q.size() < n) begin
      n_err++;
      $display("FAIL %s: timeout, got %0d of %0d ready_s pulses", name, out_q.size(), n);
    end
  endtask

  task automatic push_blk(input logic [127:0] d);
    valid_s = 1'b1;
    din     = d;
    @(negedge clk);
    valid_s = 1'b0;
  endtask

  task automatic cfg_only(input logic [1:0] m, input logic e, input logic [127:0] v);
    cfg_valid_s = 1'b1; mode = m; encrypt_decrypt_n = e; iv = v;
    @(negedge clk);
    cfg_valid_s = 1'b0;
  endtask

  task automatic cfg_push(input logic [1:0] m, input logic e, input logic [127:0] v,
                          input logic [127:0] d);
    cfg_valid_s = 1'b1; mode = m; encrypt_decrypt_n = e; iv = v;
    valid_s = 1'b1; din = d;
    @(negedge clk);
    cfg_valid_s = 1'b0;
    valid_s     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  typedef struct {
    logic [1:0]   m;
    logic         e;
    logic [127:0] v;
    logic [127:0] d;
    logic [127:0] exp;
  } vec_t;

  localparam logic [255:0] K   = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [255:0] K2  = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00011223344556677deadbeefcafef00d;
  localparam logic [127:0] P   = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] IV0 = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] IVC = 128'hdeadbeef001122334455667788995aff;

  vec_t         vecs[6];
  logic [127:0] p3[3], c3[3], q2[2], ctr2, exp_a, exp_b;
  int           cyc, log_n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b00, 1'b1, '0,  P,            tenc(K, P)};
    vecs[1] = '{2'b00, 1'b0, '0,  tenc(K, P),   P};
    vecs[2] = '{2'b01, 1'b1, IV0, P,            tenc(K, P ^ IV0)};
    vecs[3] = '{2'b01, 1'b0, IV0, tenc(K, P ^ IV0), P};
    vecs[4] = '{2'b10, 1'b1, IVC, P,            P ^ tenc(K, IVC)};
    vecs[5] = '{2'b10, 1'b0, IVC, P,            P ^ tenc(K, IVC)};

    // Reset state
    tick(2);
    check("rst_ready", ready, 0);
    check("rst_dout", dout, 0);
    check("rst_err", err, 0);
    check("rst_full", full, 0);
    check("rst_ready_s", ready_s, 0);
    check("rst_core_valid_s", core_valid_s, 0);
    reset = 1'b0;
    tick(2);
    check("ready_after_rst", ready, 1);

    // Key load with the same-cycle core strobe
    skey_valid_s = 1'b1; skey = K;
    #1;
    check("core_skey_valid_s", core_skey_valid_s, 1);
    @(negedge clk);
    skey_valid_s = 1'b0;
    cyc = 0;
    while (skey_cnt == 0 && cyc < 50) begin @(posedge clk); cyc++; end
    tick(3);
    check("skey_ready_pulses", skey_cnt, 1);

    // Single-block vectors, config applied in the same cycle as the push
    for (int i = 0; i < 6; i++) begin
      out_q.delete();
      cfg_push(vecs[i].m, vecs[i].e, vecs[i].v, vecs[i].d);
      wait_outs(1, $sformatf("vec%0d_wait", i));
      tick(4);
      check($sformatf("vec%0d_dout", i), out_at(0), vecs[i].exp);
      check($sformatf("vec%0d_pulses", i), out_q.size(), 1);
    end
    check("vec_err", err, 0);

    // CBC, 3 blocks encrypt then decrypt
    p3[0] = 128'h00000000000000000000000000000001;
    p3[1] = 128'hfedcba9876543210fedcba9876543210;
    p3[2] = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
    c3[0] = tenc(K, p3[0] ^ IV0);
    c3[1] = tenc(K, p3[1] ^ c3[0]);
    c3[2] = tenc(K, p3[2] ^ c3[1]);
    out_q.delete();
    din_log.delete();
    cfg_only(2'b01, 1'b1, IV0);
    for (int i = 0; i < 3; i++) push_blk(p3[i]);
    wait_outs(3, "cbc_enc_wait");
    for (int i = 0; i < 3; i++) check($sformatf("cbc_enc_c%0d", i), out_at(i), c3[i]);
    check("cbc_enc_core_din2", (din_log.size() > 1) ? din_log[1] : 128'hx, p3[1] ^ c3[0]);
    out_q.delete();
    cfg_only(2'b01, 1'b0, IV0);
    for (int i = 0; i < 3; i++) push_blk(c3[i]);
    wait_outs(3, "cbc_dec_wait");
    for (int i = 0; i < 3; i++) check($sformatf("cbc_dec_p%0d", i), out_at(i), p3[i]);

    // CTR with an 8-bit counter field: ff wraps to 00, byte 1 stays 5a
    q2[0] = 128'h0102030405060708090a0b0c0d0e0f10;
    q2[1] = 128'hffeeddccbbaa99887766554433221100;
    ctr2  = 128'hdeadbeef001122334455667788995a00;
    for (int r = 0; r < 2; r++) begin
      out_q.delete();
      din_log.delete();
      cfg_only(2'b10, (r == 0) ? 1'b1 : 1'b0, IVC);
      push_blk(q2[0]);
      push_blk(q2[1]);
      wait_outs(2, $sformatf("ctr%0d_wait", r));
      check($sformatf("ctr%0d_counter2", r), (din_log.size() > 1) ? din_log[1] : 128'hx, ctr2);
      check($sformatf("ctr%0d_b0", r), out_at(0), q2[0] ^ tenc(K, IVC));
      check($sformatf("ctr%0d_b1", r), out_at(1), q2[1] ^ tenc(K, ctr2));
    end

    // Key load and block push in the same cycle: block waits for the new key
    cfg_only(2'b00, 1'b1, '0);
    out_q.delete();
    log_n = skey_cnt;
    skey_valid_s = 1'b1; skey = K2; valid_s = 1'b1; din = P;
    @(negedge clk);
    skey_valid_s = 1'b0; valid_s = 1'b0;
    wait_outs(1, "key_push_wait");
    check("key_push_dout", out_at(0), tenc(K2, P));
    check("key_push_skey_ready", skey_cnt - log_n, 1);
    check("key_push_err", err, 0);

    // FIFO overflow with the core held busy; reset mode is ECB encrypt
    do_reset();
    out_q.delete();
    core_hold = 1'b1;
    for (int i = 0; i < 3; i++) push_blk(128'h1000 + 128'(i));
    check("fifo_not_full_3", full, 0);
    push_blk(128'h1003);
    check("fifo_full_4", full, 1);
    check("fifo_err_before_drop", err, 0);
    push_blk(128'h1004);
    check("fifo_drop_err", err, 1);
    check("fifo_still_full", full, 1);
    core_hold = 1'b0;
    wait_outs(4, "fifo_wait");
    tick(20);
    check("fifo_pulses", out_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("fifo_out%0d", i), out_at(i), tenc(K2, 128'h1000 + 128'(i)));

    // Illegal configs leave mode and chain untouched
    do_reset();
    out_q.delete();
    cfg_only(2'b01, 1'b1, IV0);
    check("cfg_legal_err", err, 0);
    cfg_only(2'b11, 1'b0, IVC);
    check("cfg_rsvd_err", err, 1);
    core_hold = 1'b1;
    push_blk(p3[0]);
    push_blk(p3[1]);
    cfg_only(2'b10, 1'b1, IVC);
    core_hold = 1'b0;
    exp_a = tenc(K2, p3[0] ^ IV0);
    exp_b = tenc(K2, p3[1] ^ exp_a);
    wait_outs(2, "cfg_ign_wait");
    check("cfg_ign_b0", out_at(0), exp_a);
    check("cfg_ign_b1", out_at(1), exp_b);
    check("cfg_ign_err", err, 1);

    // Reset while WAITing with 2 blocks queued
    out_q.delete();
    din_log.delete();
    core_stall = 1'b1;
    for (int i = 0; i < 3; i++) push_blk(128'h2000 + 128'(i));
    cyc = 0;
    while (din_log.size() == 0 && cyc < 50) begin @(posedge clk); cyc++; end
    tick(2);
    check("wait_issued", din_log.size(), 1);
    reset = 1'b1;
    #1;
    check("rst_mid_dout", dout, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_full", full, 0);
    check("rst_mid_ready", ready, 0);
    check("rst_mid_core_valid_s", core_valid_s, 0);
    @(negedge clk);
    reset = 1'b0;
    core_stall = 1'b0;
    out_q.delete();
    cyc = 0;
    while (!ready && cyc < 60) begin @(negedge clk); cyc++; end
    check("rst_mid_ready_back", ready, 1);
    tick(20);
    check("rst_mid_no_ready_s", out_q.size(), 0);
    check("rst_mid_no_issue", din_log.size(), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
